// File: rtl/seq_divider_pkg.sv
// Shared constants and types for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_divider_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Error quotient is all ones; sliced down to WIDTH at the use site.
    localparam logic [63:0] ERR_QUOTIENT_ONES = '1;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract, restore.
// Latency: purely combinational.
// Backpressure: none; the owning FSM decides when to register the result.
module seq_divider_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] r_cur,
    input  logic [WIDTH-1:0] q_cur,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic             carry;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH:0]   trial;
    logic             fits;

    // R < divisor on entry keeps {carry,r_sh} below 2*divisor, so trial's
    // top bit is a faithful sign.
    always_comb begin
        carry  = r_cur[WIDTH-1];
        r_sh   = {r_cur[WIDTH-2:0], q_cur[WIDTH-1]};
        trial  = {carry, r_sh} - {1'b0, divisor};
        fits   = ~trial[WIDTH];
        r_next = fits ? trial[WIDTH-1:0] : r_sh;
        q_next = {q_cur[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/seq_divider.sv
// 2W/W restoring divider, one quotient bit per clock; SEQ_DIVIDER_SIGNED_EN adds tc (two's complement).
// Latency: WIDTH+1 cycles from acceptance for a real divide, 1 cycle for divide-by-zero/overflow.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, one bubble after handshake.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic               tc,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);

    localparam int               CW    = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONES  = ERR_QUOTIENT_ONES[WIDTH-1:0];

    div_state_t       state_q, state_d;
    logic [WIDTH-1:0] r_q, q_q, dvs_q;
    logic [WIDTH-1:0] r_step, q_step;
    logic [CW-1:0]    cnt_q;
    logic             dbz_q, ovf_q;
    logic             accept, err_dbz, err_ovf;
    logic [2*WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0]   dvs_mag;

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] HALF = {1'b1, {(WIDTH-1){1'b0}}};
    logic tc_q, qneg_q, rneg_q, dvd_neg, dvs_neg, sovf;

    assign dvd_neg = tc & dividend[2*WIDTH-1];
    assign dvs_neg = tc & divisor[WIDTH-1];
    assign dvd_mag = dvd_neg ? -dividend : dividend;
    assign dvs_mag = dvs_neg ? -divisor : divisor;
    // A negative result may reach -2^(W-1); a positive one only 2^(W-1)-1.
    assign sovf    = tc_q & (qneg_q ? (q_q > HALF) : (q_q >= HALF));
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
`endif

    assign accept  = in_valid && (state_q == IDLE);
    assign err_dbz = (dvs_mag == '0);
    assign err_ovf = (dvd_mag[2*WIDTH-1:WIDTH] >= dvs_mag);

    seq_divider_step #(.WIDTH(WIDTH)) u_step (
        .r_cur   (r_q),
        .q_cur   (q_q),
        .divisor (dvs_q),
        .r_next  (r_step),
        .q_next  (q_step)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (err_dbz || err_ovf) ? DONE : CALC;
            CALC:    if (cnt_q == CW'(1)) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            q_q    <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            dbz_q  <= 1'b0;
            ovf_q  <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            tc_q   <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (accept) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
                    tc_q   <= tc;
                    qneg_q <= dvd_neg ^ dvs_neg;
                    rneg_q <= dvd_neg;
`endif
                    if (err_dbz) begin
                        dbz_q <= 1'b1;
                        q_q   <= ONES;
                        r_q   <= dividend[WIDTH-1:0];
                    end else if (err_ovf) begin
                        ovf_q <= 1'b1;
                        q_q   <= ONES;
                        r_q   <= '0;
                    end else begin
                        r_q   <= dvd_mag[2*WIDTH-1:WIDTH];
                        q_q   <= dvd_mag[WIDTH-1:0];
                        dvs_q <= dvs_mag;
                        cnt_q <= CW'(WIDTH);
                    end
                end
                CALC: begin
                    r_q   <= r_step;
                    q_q   <= q_step;
                    cnt_q <= cnt_q - CW'(1);
                end
                DONE: if (out_ready) begin
                    dbz_q <= 1'b0;
                    ovf_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready    = (state_q == IDLE) && !rst;
        out_valid   = (state_q == DONE);
        quotient    = '0;
        remainder   = '0;
        div_by_zero = 1'b0;
        overflow    = 1'b0;
        if (out_valid) begin
            quotient    = q_q;
            remainder   = r_q;
            div_by_zero = dbz_q;
            overflow    = ovf_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
            if (tc_q && !dbz_q && !ovf_q) begin
                if (sovf) begin
                    overflow  = 1'b1;
                    quotient  = ONES;
                    remainder = '0;
                end else begin
                    quotient  = qneg_q ? -q_q : q_q;
                    remainder = rneg_q ? -r_q : r_q;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: driver queues expected results from an arithmetic
// reference, a negedge monitor checks values, latency, hold-under-backpressure and the bubble.
module tb_seq_divider;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [2*W-1:0] dividend = '0;
    logic [W-1:0]  divisor = '0;
    logic          in_ready, out_valid, div_by_zero, overflow;
    logic [W-1:0]  quotient, remainder;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           lat;
        int           acc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   rdy_mode = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .tc          (1'b0),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] q, input logic [W-1:0] r,
                                input logic dbz, input logic ovf, input int lat);
        exp_t e;
        e.q = q; e.r = r; e.dbz = dbz; e.ovf = ovf; e.lat = lat; e.acc = 0;
        return e;
    endfunction

    // Reference: plain integer division; anything not fitting W bits is overflow.
    function automatic exp_t model(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        logic [63:0] qq, rr;
        if (dvs == '0) return mk('1, dvd[W-1:0], 1'b1, 1'b0, 1);
        qq = 64'(dvd) / 64'(dvs);
        rr = 64'(dvd) % 64'(dvs);
        if (qq > 64'hFFFF) return mk('1, '0, 1'b0, 1'b1, 1);
        return mk(qq[W-1:0], rr[W-1:0], 1'b0, 1'b0, W + 1);
    endfunction

    task automatic do_div_exp(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs, input exp_t e);
        int t = 0;
        @(negedge clk);
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, expected 1", t);
            in_valid = 1'b0;
            return;
        end
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = W'($urandom);
    endtask

    task automatic do_div(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs);
        do_div_exp(dvd, dvs, model(dvd, dvs));
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid || !in_ready) && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) begin
            n_cmp++; n_bad++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    // Monitor
    logic [W-1:0] h_q, h_r;
    logic         h_d, h_o;
    bit           seen = 0;
    bit           pend = 0;
    exp_t         cur;

    always @(negedge clk) begin
        if (rst) begin
            seen = 0;
            pend = 0;
        end else begin
            if (pend) begin
                chk("in_ready_after_handshake", 64'(in_ready), 64'd1);
                pend = 0;
            end
            if (out_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++; n_bad++;
                        $display("FAIL unexpected_result: q=0x%0h r=0x%0h with no request outstanding",
                                 quotient, remainder);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("quotient", 64'(quotient), 64'(cur.q));
                        chk("remainder", 64'(remainder), 64'(cur.r));
                        chk("div_by_zero", 64'(div_by_zero), 64'(cur.dbz));
                        chk("overflow", 64'(overflow), 64'(cur.ovf));
                        chk("latency", 64'(cyc - cur.acc + 1), 64'(cur.lat));
                    end
                    h_q = quotient; h_r = remainder; h_d = div_by_zero; h_o = overflow;
                    seen = 1;
                end else begin
                    chk("hold_quotient", 64'(quotient), 64'(h_q));
                    chk("hold_remainder", 64'(remainder), 64'(h_r));
                    chk("hold_flags", 64'({div_by_zero, overflow}), 64'({h_d, h_o}));
                end
                chk("in_ready_while_done", 64'(in_ready), 64'd0);
                if (out_ready) begin
                    seen = 0;
                    pend = 1;
                end
            end
        end
    end

    initial begin
        logic [W-1:0]   a, b;
        logic [2*W-1:0] dvd;
        int             t;

        repeat (3) @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_quotient", 64'(quotient), 64'd0);
        chk("reset_remainder", 64'(remainder), 64'd0);
        chk("reset_flags", 64'({div_by_zero, overflow}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        do_div_exp(32'd1000, 16'd7, mk(16'd142, 16'd6, 1'b0, 1'b0, 17));
        do_div_exp(32'hFFFE0001, 16'hFFFF, mk(16'hFFFF, 16'd0, 1'b0, 1'b0, 17));
        do_div_exp(32'h12345678, 16'd0, mk(16'hFFFF, 16'h5678, 1'b1, 1'b0, 1));
        do_div_exp(32'h00010000, 16'd1, mk(16'hFFFF, 16'd0, 1'b0, 1'b1, 1));
        do_div_exp(32'h0000FFFF, 16'd1, mk(16'hFFFF, 16'd0, 1'b0, 1'b0, 17));
        wait_idle();

        // Hold the result for five cycles under backpressure.
        rdy_mode = 1;
        do_div_exp(32'd1000, 16'd7, mk(16'd142, 16'd6, 1'b0, 1'b0, 17));
        t = 0;
        while (!out_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        rdy_mode = 0;
        wait_idle();

        // Product of two 16-bit values divided back by one factor.
        for (int i = 0; i < 20; i++) begin
            a = W'($urandom);
            b = W'($urandom_range(1, 65535));
            do_div_exp(32'(a) * 32'(b), b, mk(a, 16'd0, 1'b0, 1'b0, 17));
        end
        wait_idle();

        rdy_mode = 2;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 9))
                0: do_div($urandom, 16'd0);
                1, 2: do_div($urandom, W'($urandom));
                default: begin
                    b = W'($urandom_range(1, 65535));
                    dvd = {W'($urandom % b), W'($urandom)};
                    do_div(dvd, b);
                end
            endcase
        end
        rdy_mode = 0;
        wait_idle();

        // Abort mid-calculation: the dropped request must never produce a result.
        do_div_exp(32'h00001234, 16'd7, mk(16'd0, 16'd0, 1'b0, 1'b0, 17));
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_in_ready", 64'(in_ready), 64'd0);
        chk("abort_quotient", 64'(quotient), 64'd0);
        chk("abort_remainder", 64'(remainder), 64'd0);
        chk("abort_flags", 64'({div_by_zero, overflow}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_abort", 64'(in_ready), 64'd1);
        do_div_exp(32'd100, 16'd3, mk(16'd33, 16'd1, 1'b0, 1'b0, 17));
        wait_idle();
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
